irq_ctrl: RTL and testbench

- External/software interrupt controller that sits directly upstream of the CP0 register file in the MIPS54 CPU.
- Synchronises raw interrupt lines, holds pending state, and applies a mask and fixed priority.
- Presents a single registered request with exception code and line id to the control unit / CP0.
- Tracks in-service state until the handler executes eret.

---
 rtl/irq_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_irq_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : irq_ctrl
// Purpose  : Interrupt controller upstream of CP0. It synchronises the raw
//            lines, keeps pending/mask/edge state, arbitrates by fixed
//            priority and tracks in-service until eret.
// Options  : IRQ_NEST_EN adds a nested in-service bitmask (ISR).
// Revision : 1.0 - initial release
// ============================================================================
module irq_ctrl #(
  parameter int N_IRQ       = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             status_ie,
  input  logic             eret,
  input  logic             irq_ack,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  output logic [31:0]      cfg_rdata,
  output logic             irq_req,
  output logic [2:0]       irq_id,
  output logic [4:0]       irq_cause,
  output logic             in_service
);

  localparam logic [4:0] c_EXC_INT = 5'd0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_req;
  logic [2:0]       r_id;
  logic [N_IRQ-1:0] r_sync [SYNC_STAGES];
  logic [N_IRQ-1:0] r_prev;
  logic [N_IRQ-1:0] r_mask;
  logic [N_IRQ-1:0] r_edge;
  logic [N_IRQ-1:0] r_pend;
  logic [N_IRQ-1:0] w_s;
  logic [N_IRQ-1:0] w_pend_nxt;
  logic [N_IRQ-1:0] w_cand;
  logic [N_IRQ-1:0] w_w1c;
  logic [2:0]       w_win;
  logic             w_any;
  logic             w_ack_take;
  logic             w_wr_mask;
  logic             w_wr_edge;
  logic             w_wr_pend;
  logic [7:0]       w_mask8;
  logic [7:0]       w_edge8;
  logic [7:0]       w_pend8;
  logic             w_unused;

  assign w_unused = ^cfg_wdata[31:N_IRQ];

  // ---------------- input synchronisers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= irq_in;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      r_prev <= w_s;
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // ---------------- config decode ----------------
  assign w_wr_mask  = cfg_we && (cfg_addr == 2'd0);
  assign w_wr_edge  = cfg_we && (cfg_addr == 2'd1);
  assign w_wr_pend  = cfg_we && (cfg_addr == 2'd2);
  assign w_w1c      = w_wr_pend ? cfg_wdata[N_IRQ-1:0] : '0;
  assign w_ack_take = irq_ack && (r_state == ST_REQ);

  // Edge lines latch until cleared (set beats clear); level lines follow s.
  for (genvar i = 0; i < N_IRQ; i++) begin : g_pend
    localparam logic [2:0] c_IDX = 3'(i);
    logic w_set;
    logic w_clr;
    assign w_set         = w_s[i] & ~r_prev[i];
    assign w_clr         = w_w1c[i] | (w_ack_take & (r_id == c_IDX));
    assign w_pend_nxt[i] = r_edge[i] ? (w_set | (r_pend[i] & ~w_clr)) : w_s[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask <= '0;
      r_edge <= '0;
      r_pend <= '0;
    end else begin
      if (w_wr_mask) r_mask <= cfg_wdata[N_IRQ-1:0];
      if (w_wr_edge) r_edge <= cfg_wdata[N_IRQ-1:0];
      r_pend <= w_pend_nxt;
    end
  end

  // ---------------- arbitration ----------------
  assign w_cand = r_pend & r_mask;
  assign w_any  = |w_cand;

  always_comb begin
    w_win = 3'd0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_cand[i]) w_win = 3'(i);
    end
  end

`ifdef IRQ_NEST_EN
  logic [N_IRQ-1:0] r_isr;
  logic [N_IRQ-1:0] w_isr_low_1h;
  logic [N_IRQ-1:0] w_isr_after_eret;
  logic [N_IRQ-1:0] w_id_1h;
  logic [2:0]       w_isr_lo;
  logic [7:0]       w_isr8;

  assign w_isr_low_1h     = r_isr & (~r_isr + N_IRQ'(1));
  assign w_isr_after_eret = r_isr & ~w_isr_low_1h;
  assign w_id_1h          = N_IRQ'(1) << r_id;

  always_comb begin
    w_isr_lo = 3'd0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (r_isr[i]) w_isr_lo = 3'(i);
    end
  end

  always_comb begin
    w_isr8 = '0;
    w_isr8[N_IRQ-1:0] = r_isr;
  end

  assign in_service = |r_isr;
`else
  logic r_in_service;
  assign in_service = r_in_service;
`endif

  // ---------------- request / service FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
      r_id    <= 3'd0;
`ifdef IRQ_NEST_EN
      r_isr   <= '0;
`else
      r_in_service <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any && status_ie) begin
            r_state <= ST_REQ;
            r_req   <= 1'b1;
            r_id    <= w_win;
          end
        end
        ST_REQ: begin
          if (irq_ack) begin
            r_state <= ST_SERVICE;
            r_req   <= 1'b0;
`ifdef IRQ_NEST_EN
            r_isr   <= r_isr | w_id_1h;
`else
            r_in_service <= 1'b1;
`endif
          end else if (!status_ie || !w_cand[r_id]) begin
            r_req <= 1'b0;
`ifdef IRQ_NEST_EN
            r_state <= (r_isr != '0) ? ST_SERVICE : ST_IDLE;
`else
            r_state <= ST_IDLE;
`endif
          end
        end
        ST_SERVICE: begin
`ifdef IRQ_NEST_EN
          // Only a strictly higher-priority line than the active one may preempt.
          if (eret) begin
            r_isr <= w_isr_after_eret;
            if (w_isr_after_eret == '0) r_state <= ST_IDLE;
          end else if (w_any && status_ie && (w_win < w_isr_lo)) begin
            r_state <= ST_REQ;
            r_req   <= 1'b1;
            r_id    <= w_win;
          end
`else
          if (eret) begin
            r_state      <= ST_IDLE;
            r_in_service <= 1'b0;
          end
`endif
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign irq_req   = r_req;
  assign irq_id    = r_id;
  assign irq_cause = r_req ? c_EXC_INT : 5'd0;

  // ---------------- config readback ----------------
  always_comb begin
    w_mask8 = '0;
    w_edge8 = '0;
    w_pend8 = '0;
    w_mask8[N_IRQ-1:0] = r_mask;
    w_edge8[N_IRQ-1:0] = r_edge;
    w_pend8[N_IRQ-1:0] = r_pend;
  end

  always_comb begin
    cfg_rdata = 32'd0;
    case (cfg_addr)
      2'd0:    cfg_rdata = {24'd0, w_mask8};
      2'd1:    cfg_rdata = {24'd0, w_edge8};
`ifdef IRQ_NEST_EN
      2'd2:    cfg_rdata = {16'd0, w_isr8, w_pend8};
`else
      2'd2:    cfg_rdata = {24'd0, w_pend8};
`endif
      default: cfg_rdata = {29'd0, w_win};
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_ctrl
// Purpose  : Directed scenarios plus a randomized run against a reference
//            model of the pending/priority/service rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl;
  localparam int N  = 6;
  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  irq_in;
  logic        status_ie, eret, irq_ack, cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata, cfg_rdata;
  logic        irq_req;
  logic [2:0]  irq_id;
  logic [4:0]  irq_cause;
  logic        in_service;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  irq_ctrl #(.N_IRQ(N), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .status_ie(status_ie),
    .eret(eret), .irq_ack(irq_ack), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .irq_req(irq_req),
    .irq_id(irq_id), .irq_cause(irq_cause), .in_service(in_service)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    irq_in = '0; status_ie = 0; eret = 0; irq_ack = 0;
    cfg_we = 0; cfg_addr = 0; cfg_wdata = 0;
    rst = 1;
    ticks(2);
    rst = 0;
    tick();
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 0; cfg_wdata = 0;
  endtask

  task automatic cfg_read(input logic [1:0] a, output logic [31:0] d);
    cfg_addr = a;
    #1;
    d = cfg_rdata;
  endtask

  task automatic pulse_ack();
    irq_ack = 1; tick(); irq_ack = 0;
  endtask

  task automatic pulse_eret();
    eret = 1; tick(); eret = 0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %0b want 0", irq_req); end
    total++; if (irq_id !== 3'd0) begin bad++; $display("FAIL reset_id: got %0d want 0", irq_id); end
    total++; if (irq_cause !== 5'd0) begin bad++; $display("FAIL reset_cause: got %0h want 0", irq_cause); end
    total++; if (in_service !== 1'b0) begin bad++; $display("FAIL reset_insvc: got %0b want 0", in_service); end
    for (int a = 0; a < 4; a++) begin
      cfg_read(2'(a), d);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL reset_rd%0d: got %0h want 0", a, d); end
    end
  endtask

  task automatic test_level();
    do_reset();
    cfg_write(2'd0, 32'h3F);
    cfg_write(2'd1, 32'h00);
    status_ie = 1;
    irq_in = 6'b000100;
    ticks(3);
    total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL lvl_early: got %0b want 0", irq_req); end
    tick();
    total++; if (irq_req !== 1'b1) begin bad++; $display("FAIL lvl_req: got %0b want 1", irq_req); end
    total++; if (irq_id !== 3'd2) begin bad++; $display("FAIL lvl_id: got %0d want 2", irq_id); end
    total++; if (irq_cause !== 5'd0) begin bad++; $display("FAIL lvl_cause: got %0h want 0", irq_cause); end
    pulse_ack();
    total++; if (irq_req !== 1'b0 || in_service !== 1'b1) begin bad++; $display("FAIL lvl_ack: got req=%0b svc=%0b want 0/1", irq_req, in_service); end
    ticks(2);
    total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL lvl_svc_noreq: got %0b want 0", irq_req); end
    pulse_eret();
    total++; if (in_service !== 1'b0 || irq_req !== 1'b0) begin bad++; $display("FAIL lvl_eret: got req=%0b svc=%0b want 0/0", irq_req, in_service); end
    tick();
    total++; if (irq_req !== 1'b1 || irq_id !== 3'd2) begin bad++; $display("FAIL lvl_rereq: got req=%0b id=%0d want 1/2", irq_req, irq_id); end
  endtask

  task automatic test_edge();
    logic [31:0] d;
    do_reset();
    cfg_write(2'd0, 32'h3F);
    cfg_write(2'd1, 32'h3F);
    status_ie = 1;
    irq_in = 6'b010010;
    ticks(3);
    irq_in = '0;
    tick();
    total++; if (irq_req !== 1'b1 || irq_id !== 3'd1) begin bad++; $display("FAIL edge_req1: got req=%0b id=%0d want 1/1", irq_req, irq_id); end
    ticks(2);
    cfg_read(2'd2, d);
    total++; if (d !== 32'h12) begin bad++; $display("FAIL edge_pend: got %0h want 12", d); end
    cfg_read(2'd3, d);
    total++; if (d !== 32'd1) begin bad++; $display("FAIL edge_vec: got %0h want 1", d); end
    pulse_ack();
    cfg_read(2'd2, d);
    total++; if (d !== 32'h10) begin bad++; $display("FAIL edge_ackclr: got %0h want 10", d); end
    pulse_eret();
    tick();
    total++; if (irq_req !== 1'b1 || irq_id !== 3'd4) begin bad++; $display("FAIL edge_req4: got req=%0b id=%0d want 1/4", irq_req, irq_id); end
    cfg_write(2'd2, 32'h10);
    cfg_read(2'd2, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL edge_w1c: got %0h want 0", d); end
    tick();
    total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL edge_withdraw: got %0b want 0", irq_req); end
    ticks(3);
    total++; if (irq_req !== 1'b0 || in_service !== 1'b0) begin bad++; $display("FAIL edge_idle: got req=%0b svc=%0b want 0/0", irq_req, in_service); end
  endtask

  task automatic test_ie();
    logic [31:0] d;
    do_reset();
    cfg_write(2'd0, 32'h3F);
    cfg_write(2'd1, 32'h3F);
    status_ie = 1;
    irq_in = 6'b000001;
    ticks(3);
    irq_in = '0;
    tick();
    total++; if (irq_req !== 1'b1 || irq_id !== 3'd0) begin bad++; $display("FAIL ie_req: got req=%0b id=%0d want 1/0", irq_req, irq_id); end
    status_ie = 0;
    tick();
    total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL ie_withdraw: got %0b want 0", irq_req); end
    cfg_read(2'd2, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL ie_pend: got %0h want 1", d); end
    status_ie = 1;
    tick();
    total++; if (irq_req !== 1'b1 || irq_id !== 3'd0) begin bad++; $display("FAIL ie_rereq: got req=%0b id=%0d want 1/0", irq_req, irq_id); end
  endtask

  task automatic test_mask();
    logic [31:0] d;
    int seen;
    do_reset();
    status_ie = 1;
    irq_in = 6'h3F;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (irq_req !== 1'b0) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL mask_noreq: got %0d req cycles want 0", seen); end
    cfg_read(2'd3, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL mask_vec0: got %0h want 0", d); end
    cfg_read(2'd2, d);
    total++; if (d !== 32'h3F) begin bad++; $display("FAIL mask_pend: got %0h want 3f", d); end
    cfg_write(2'd1, 32'hFFFF_FFC0);
    cfg_read(2'd1, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL mask_edge_hi: got %0h want 0", d); end
    cfg_write(2'd0, 32'hFFFF_FF30);
    cfg_read(2'd0, d);
    total++; if (d !== 32'h30) begin bad++; $display("FAIL mask_rd: got %0h want 30", d); end
    total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL mask_same_edge: got %0b want 0", irq_req); end
    cfg_read(2'd3, d);
    total++; if (d !== 32'd4) begin bad++; $display("FAIL mask_vec4: got %0h want 4", d); end
    cfg_write(2'd3, 32'h7);
    cfg_read(2'd3, d);
    total++; if (d !== 32'd4) begin bad++; $display("FAIL vec_ro: got %0h want 4", d); end
    total++; if (irq_req !== 1'b1 || irq_id !== 3'd4) begin bad++; $display("FAIL mask_req4: got req=%0b id=%0d want 1/4", irq_req, irq_id); end
  endtask

  task automatic test_rst_mid();
    logic [31:0] d;
    do_reset();
    cfg_write(2'd0, 32'h3F);
    cfg_write(2'd1, 32'h3F);
    status_ie = 1;
    irq_in = 6'b101000;
    ticks(3);
    irq_in = '0;
    tick();
    total++; if (irq_req !== 1'b1 || irq_id !== 3'd3) begin bad++; $display("FAIL rst_req3: got req=%0b id=%0d want 1/3", irq_req, irq_id); end
    pulse_ack();
    cfg_read(2'd2, d);
    total++; if (d !== 32'h20 || in_service !== 1'b1) begin bad++; $display("FAIL rst_presvc: got pend=%0h svc=%0b want 20/1", d, in_service); end
    #1;
    rst = 1;
    #1;
    total++; if (irq_req !== 1'b0 || irq_id !== 3'd0 || irq_cause !== 5'd0 || in_service !== 1'b0)
      begin bad++; $display("FAIL rst_async_out: got req=%0b id=%0d cause=%0h svc=%0b want 0", irq_req, irq_id, irq_cause, in_service); end
    for (int a = 0; a < 4; a++) begin
      cfg_read(2'(a), d);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL rst_rd%0d: got %0h want 0", a, d); end
    end
    ticks(2);
    rst = 0;
    cfg_write(2'd0, 32'h3F);
    cfg_write(2'd1, 32'h3F);
    ticks(6);
    total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL rst_quiet: got %0b want 0", irq_req); end
    irq_in = 6'b100000;
    ticks(3);
    irq_in = '0;
    tick();
    total++; if (irq_req !== 1'b1 || irq_id !== 3'd5) begin bad++; $display("FAIL rst_newedge: got req=%0b id=%0d want 1/5", irq_req, irq_id); end
  endtask

`ifdef IRQ_NEST_EN
  task automatic pulse_line(input int ln);
    irq_in = 6'(1 << ln);
    ticks(3);
    irq_in = '0;
  endtask

  task automatic test_nest();
    logic [31:0] d;
    do_reset();
    cfg_write(2'd0, 32'h3F);
    cfg_write(2'd1, 32'h3F);
    status_ie = 1;
    pulse_line(3);
    tick();
    total++; if (irq_req !== 1'b1 || irq_id !== 3'd3) begin bad++; $display("FAIL nest_req3: got req=%0b id=%0d want 1/3", irq_req, irq_id); end
    pulse_ack();
    pulse_line(1);
    tick();
    total++; if (irq_req !== 1'b1 || irq_id !== 3'd1 || in_service !== 1'b1) begin bad++; $display("FAIL nest_req1: got req=%0b id=%0d svc=%0b want 1/1/1", irq_req, irq_id, in_service); end
    pulse_ack();
    cfg_read(2'd2, d);
    total++; if (d !== 32'h0A00) begin bad++; $display("FAIL nest_isr: got %0h want a00", d); end
    pulse_line(5);
    ticks(4);
    total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL nest_low_blocked: got %0b want 0", irq_req); end
    pulse_eret();
    total++; if (in_service !== 1'b1 || irq_req !== 1'b0) begin bad++; $display("FAIL nest_eret1: got svc=%0b req=%0b want 1/0", in_service, irq_req); end
    pulse_eret();
    total++; if (in_service !== 1'b0) begin bad++; $display("FAIL nest_eret2: got %0b want 0", in_service); end
    tick();
    total++; if (irq_req !== 1'b1 || irq_id !== 3'd5) begin bad++; $display("FAIL nest_req5: got req=%0b id=%0d want 1/5", irq_req, irq_id); end
  endtask
`else
  // Reference model: rules applied to abstract state, updated once per edge.
  logic [5:0] m_pipe [SS];
  logic [5:0] m_prev, m_pend, m_mask, m_edge;
  int         m_st;
  int         m_id;

  function automatic int lowest(input logic [5:0] v);
    for (int i = 0; i < 6; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_step(input logic [5:0] in, input logic ie, input logic ack,
                            input logic er, input logic we, input logic [1:0] a,
                            input logic [31:0] wd);
    logic [5:0] s, cand, pn;
    int st_n, id_n, w;
    s    = m_pipe[SS-1];
    cand = m_pend & m_mask;
    w    = lowest(cand);
    st_n = m_st; id_n = m_id;
    if (m_st == 0) begin
      if (w >= 0 && ie) begin st_n = 1; id_n = w; end
    end else if (m_st == 1) begin
      if (ack) st_n = 2;
      else if (!ie || !cand[m_id]) st_n = 0;
    end else begin
      if (er) st_n = 0;
    end
    for (int i = 0; i < 6; i++) begin
      logic clr;
      clr = (we && a == 2'd2 && wd[i]) || (ack && m_st == 1 && m_id == i);
      if (m_edge[i]) pn[i] = (s[i] && !m_prev[i]) || (m_pend[i] && !clr);
      else           pn[i] = s[i];
    end
    if (we && a == 2'd0) m_mask = wd[5:0];
    if (we && a == 2'd1) m_edge = wd[5:0];
    m_pend = pn;
    m_prev = s;
    for (int k = SS - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
    m_pipe[0] = in;
    m_st = st_n;
    m_id = id_n;
  endtask

  task automatic test_random();
    logic [31:0] d, exp;
    logic [1:0]  ra;
    int w;
    do_reset();
    for (int k = 0; k < SS; k++) m_pipe[k] = '0;
    m_prev = '0; m_pend = '0; m_mask = '0; m_edge = '0; m_st = 0; m_id = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ($urandom % 4 == 0) irq_in = 6'($urandom);
      status_ie = ($urandom % 8) != 0;
      irq_ack   = irq_req ? ($urandom % 3 == 0) : ($urandom % 16 == 0);
      eret      = ($urandom % 5) == 0;
      cfg_we    = ($urandom % 8) == 0;
      cfg_addr  = 2'($urandom);
      cfg_wdata = $urandom;
      model_step(irq_in, status_ie, irq_ack, eret, cfg_we, cfg_addr, cfg_wdata);
      tick();
      cfg_we = 0; irq_ack = 0; eret = 0;
      total++; if (irq_req !== (m_st == 1)) begin bad++; $display("FAIL rnd_req c%0d: got %0b want %0b", cyc, irq_req, m_st == 1); end
      total++; if (in_service !== (m_st == 2)) begin bad++; $display("FAIL rnd_svc c%0d: got %0b want %0b", cyc, in_service, m_st == 2); end
      if (m_st == 1) begin
        total++; if (irq_id !== 3'(m_id) || irq_cause !== 5'd0) begin bad++; $display("FAIL rnd_id c%0d: got %0d/%0h want %0d/0", cyc, irq_id, irq_cause, m_id); end
      end
      ra = 2'($urandom);
      case (ra)
        2'd0: exp = {26'd0, m_mask};
        2'd1: exp = {26'd0, m_edge};
        2'd2: exp = {26'd0, m_pend};
        default: begin
          w = lowest(m_pend & m_mask);
          exp = (w < 0) ? 32'd0 : 32'(w);
        end
      endcase
      cfg_read(ra, d);
      total++; if (d !== exp) begin bad++; $display("FAIL rnd_rd%0d c%0d: got %0h want %0h", ra, cyc, d, exp); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_level();
    test_edge();
    test_ie();
    test_mask();
    test_rst_mid();
`ifdef IRQ_NEST_EN
    test_nest();
`else
    test_random();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
